alu_arbiter: RTL and testbench

- Shares one registered ALU (two W-bit operands, 2-bit op, result registered on clk when enabled) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, sequences the ALU enable, captures the result and returns it to the winning requester.
- Sits between the ALU and its two masters in the datapath.

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two valid/ready requesters.
// Round-robin arbitration in IDLE. The operation then runs EXEC -> WAIT -> RESP
// and the result goes back to the requester that won.
// Optional feature: define ALU_ARB_STATS_EN to add saturating per-requester
// grant counters (grant_cnt0/grant_cnt1).
module alu_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [1:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_c,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_c,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_en,
    input  logic [W-1:0]     alu_c,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant;
    logic           r_owner;
    logic           w_sel;
    logic           w_accept;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [1:0]     r_alu_op;
    logic [W-1:0]   r_rsp0_c;
    logic [W-1:0]   r_rsp1_c;

    // Round-robin select: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        w_sel = ~r_last_grant;
        if (req0_valid && !req1_valid) begin
            w_sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_sel = 1'b1;
        end
    end

    // A request is accepted only in IDLE and never while reset is asserted.
    assign w_accept   = (r_state == S_IDLE) && !reset && (req0_valid || req1_valid);
    assign req0_ready = w_accept && req0_valid && (w_sel == 1'b0);
    assign req1_ready = w_accept && req1_valid && (w_sel == 1'b1);

    // Next-state logic for the operation sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_EXEC;
            S_EXEC: w_next_state = S_WAIT;
            S_WAIT: w_next_state = S_RESP;
            S_RESP: begin
                if ((r_owner == 1'b0) ? rsp0_ready : rsp1_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the winner's operands on accept, and capture the ALU result in WAIT for the owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp0_c     <= '0;
            r_rsp1_c     <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_sel ? req1_a  : req0_a;
                r_alu_b      <= w_sel ? req1_b  : req0_b;
                r_alu_op     <= w_sel ? req1_op : req0_op;
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
            end
            if (r_state == S_WAIT) begin
                if (r_owner == 1'b0) begin
                    r_rsp0_c <= alu_c;
                end else begin
                    r_rsp1_c <= alu_c;
                end
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_en     = (r_state == S_EXEC);
    assign busy       = (r_state != S_IDLE);
    assign rsp0_valid = (r_state == S_RESP) && (r_owner == 1'b0);
    assign rsp1_valid = (r_state == S_RESP) && (r_owner == 1'b1);
    assign rsp0_c     = r_rsp0_c;
    assign rsp1_c     = r_rsp1_c;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Saturating grant counters, bumped on each requester's accept cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (req0_ready && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (req1_ready && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural registered ALU is attached
// to the ALU port. Expected results are queued per requester on every accept
// and compared when the response handshake happens.
// Define ALU_ARB_STATS_EN to also exercise the grant counters (CNT_W=2).
module tb_alu_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_c, rsp1_c;
    logic [1:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic         alu_en, busy;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en), .alu_c(alu_c),
        .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Behavioural registered ALU.
    always @(posedge clk) begin
        if (alu_en) alu_c <= alu_model(alu_a, alu_b, alu_op);
    end

    // Scoreboard monitor: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready) q0.push_back(alu_model(req0_a, req0_b, req0_op));
            if (req1_valid && req1_ready) q1.push_back(alu_model(req1_a, req1_b, req1_op));
            if (rsp0_valid && rsp0_ready) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_rsp0: unexpected response c=%h, nothing outstanding", rsp0_c);
                end else begin
                    logic [W-1:0] exp0;
                    exp0 = q0.pop_front();
                    if (rsp0_c !== exp0) begin
                        n_errors++;
                        $display("FAIL sb_rsp0: got %h expected %h", rsp0_c, exp0);
                    end
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_rsp1: unexpected response c=%h, nothing outstanding", rsp1_c);
                end else begin
                    logic [W-1:0] exp1;
                    exp1 = q1.pop_front();
                    if (rsp1_c !== exp1) begin
                        n_errors++;
                        $display("FAIL sb_rsp1: got %h expected %h", rsp1_c, exp1);
                    end
                end
            end
        end
        n_checks++;
        if ((req0_ready && req1_ready) || (rsp0_valid && rsp1_valid)) begin
            n_errors++;
            $display("FAIL exclusive: ready=%b%b rsp_valid=%b%b", req0_ready, req1_ready,
                     rsp0_valid, rsp1_valid);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    task automatic drain();
        clear_inputs();
        rsp0_ready = 1;
        rsp1_ready = 1;
        repeat (6) next_cycle();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_idle: busy=%b expected 0", busy);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en, busy} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: r0r1 v0v1 en busy=%b expected 000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en, busy});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_op, rsp0_c, rsp1_c} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: alu_a=%h alu_b=%h op=%h c0=%h c1=%h expected 0",
                     alu_a, alu_b, alu_op, rsp0_c, rsp1_c);
        end
        next_cycle();
        clear_inputs();
        reset = 0;
        next_cycle();
    endtask

    task automatic test_single_add();
        do_reset();
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 2'd0; rsp0_ready = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (req0_ready !== (c == 0)) begin
                n_errors++;
                $display("FAIL single_ready c%0d: got %b expected %b", c, req0_ready, c == 0);
            end
            n_checks++;
            if (alu_en !== (c == 1)) begin
                n_errors++;
                $display("FAIL single_alu_en c%0d: got %b expected %b", c, alu_en, c == 1);
            end
            n_checks++;
            if (rsp0_valid !== (c == 3)) begin
                n_errors++;
                $display("FAIL single_rsp_valid c%0d: got %b expected %b", c, rsp0_valid, c == 3);
            end
            if (c == 1) begin
                n_checks++;
                if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 2'd0) begin
                    n_errors++;
                    $display("FAIL single_operands: a=%h b=%h op=%h expected 5 7 0", alu_a, alu_b, alu_op);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (rsp0_c !== 32'd12) begin
                    n_errors++;
                    $display("FAIL single_result: got %h expected 0000000c", rsp0_c);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_busy_c4: got %b expected 0", busy);
                end
            end
            next_cycle();
            req0_valid = 0;
        end
        drain();
    endtask

    task automatic test_contention();
        int grants[$];
        int times[$];
        do_reset();
        req0_valid = 1; req0_a = 3;     req0_b = 5;     req0_op = 2'd1;
        req1_valid = 1; req1_a = 'hF0;  req1_b = 'h0F;  req1_op = 2'd3;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (req0_ready) begin grants.push_back(0); times.push_back(c); end
            if (req1_ready) begin grants.push_back(1); times.push_back(c); end
            if (rsp0_valid) begin
                n_checks++;
                if (rsp0_c !== 32'hFFFF_FFFE) begin
                    n_errors++;
                    $display("FAIL contention_sub: got %h expected fffffffe", rsp0_c);
                end
            end
            if (rsp1_valid) begin
                n_checks++;
                if (rsp1_c !== 32'h0000_00FF) begin
                    n_errors++;
                    $display("FAIL contention_or: got %h expected 000000ff", rsp1_c);
                end
            end
            next_cycle();
        end
        n_checks++;
        if (grants.size() != 4) begin
            n_errors++;
            $display("FAIL contention_count: got %0d grants expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grants[i] != (i % 2) || times[i] != 4 * i) begin
                    n_errors++;
                    $display("FAIL contention_grant%0d: got req%0d at c%0d expected req%0d at c%0d",
                             i, grants[i], times[i], i % 2, 4 * i);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1; req1_a = 32'hFFFF_0000; req1_b = 32'h00FF_FF00; req1_op = 2'd2;
        rsp1_ready = 0;
        @(negedge clk);
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_accept1: got %b expected 1", req1_ready);
        end
        next_cycle();
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 2'd0;
        rsp0_ready = 1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 8) rsp1_ready = 1;
            @(negedge clk);
            n_checks++;
            if (req0_ready !== (c == 9)) begin
                n_errors++;
                $display("FAIL bp_req0_ready c%0d: got %b expected %b", c, req0_ready, c == 9);
            end
            if (c >= 3 && c <= 8) begin
                n_checks++;
                if (rsp1_valid !== 1'b1 || rsp1_c !== 32'h00FF_0000) begin
                    n_errors++;
                    $display("FAIL bp_hold c%0d: valid=%b c=%h expected 1 00ff0000", c, rsp1_valid, rsp1_c);
                end
            end
            next_cycle();
        end
        req0_valid = 0;
        rsp1_ready = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (rsp0_valid !== 1'b1 || rsp0_c !== 32'd0) begin
            n_errors++;
            $display("FAIL wrap_add: valid=%b c=%h expected 1 00000000", rsp0_valid, rsp0_c);
        end
        next_cycle();
        drain();
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 2'd0; rsp0_ready = 1;
        next_cycle();
        req0_valid = 0;
        reset = 1;
        @(negedge clk);
        n_checks++;
        if (alu_en !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_exec: alu_en=%b expected 1", alu_en);
        end
        next_cycle();
        reset = 0;
        @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en, busy} !== 6'b0 ||
            {alu_a, alu_b, alu_op, rsp0_c, rsp1_c} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_vals: ctrl=%b alu_a=%h alu_b=%h c0=%h expected all 0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_en, busy}, alu_a, alu_b, rsp0_c);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            if (rsp0_valid) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_no_rsp: rsp0_valid seen=%b expected 0", seen);
        end
        next_cycle();
        req0_valid = 1; req0_a = 9; req0_b = 4; req0_op = 2'd1;
        req1_valid = 1; req1_a = 6; req1_b = 3; req1_op = 2'd2;
        rsp1_ready = 1;
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_first_grant: ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
        end
        next_cycle();
        drain();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        logic [CNT_W-1:0] exp_cnt[5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        do_reset();
        rsp0_ready = 1;
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1; req0_a = k; req0_b = 1; req0_op = 2'd0;
            next_cycle();
            req0_valid = 0;
            @(negedge clk);
            n_checks++;
            if (grant_cnt0 !== exp_cnt[k] || grant_cnt1 !== '0) begin
                n_errors++;
                $display("FAIL stats%0d: cnt0=%0d cnt1=%0d expected %0d 0", k, grant_cnt0, grant_cnt1, exp_cnt[k]);
            end
            repeat (3) next_cycle();
        end
        drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1;
        next_cycle();
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL sb_empty: outstanding q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
